vscale_dmem_bridge: RTL and testbench

AHB-Lite master bridge sitting directly downstream of the core's data-memory port. It consumes the core's dmem request signals (dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed) and turns them into pipelined single AHB-Lite transfers. It returns aligned, sign- or zero-extended load data and a wait signal to the core, and flags misaligned accesses and bus errors.

---
 rtl/vscale_dmem_bridge.sv | 171 +++++++++++++++++
 tb/tb_vscale_dmem_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge
// AHB-Lite master bridge for the core's data-memory port. Each core
// request becomes a single NONSEQ transfer. The address phase is
// combinational from the core inputs. The data phase is tracked in
// dp_* registers, which capture the information needed to steer store
// data and extract load data one accepted cycle later.
module vscale_dmem_bridge #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        hclk,
    input  logic        reset,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic [31:0] dmem_rdata,
    output logic        dmem_wait,
    output logic        dmem_badmem_e,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [0:0] ST_IDLE_OK = 1'b0;
    localparam logic [0:0] ST_ERR2    = 1'b1;

    logic [0:0] state_q, state_d;
    logic       dp_valid_q, dp_valid_d;
    logic       dp_write_q, dp_write_d;
    logic [1:0] dp_size_q, dp_size_d;
    logic       dp_unsigned_q, dp_unsigned_d;
    logic [1:0] dp_off_q, dp_off_d;

    logic        size_legal_s;
    logic        misaligned_s;
    logic        req_illegal_s;
    logic        accept_s;
    logic        load_done_s;
    logic [7:0]  rd_byte_s;
    logic [15:0] rd_half_s;
    logic [31:0] rd_ext_s;

    // Classify the incoming request: legal size and natural alignment.
    always_comb begin
        size_legal_s = 1'b0;
        misaligned_s = 1'b0;
        case (dmem_size)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: size_legal_s = 1'b1;
            default:                      size_legal_s = 1'b0;
        endcase
        case (dmem_size[1:0])
            2'd1:    misaligned_s = dmem_addr[0];
            2'd2:    misaligned_s = (dmem_addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        req_illegal_s = !size_legal_s || misaligned_s;
    end

    // Address phase: issue NONSEQ only for legal requests outside the ERROR tail.
    always_comb begin
        if (dmem_en && !req_illegal_s && (state_q != ST_ERR2)) begin
            htrans = HTRANS_NONSEQ;
        end else begin
            htrans = HTRANS_IDLE;
        end
        haddr     = dmem_addr;
        hwrite    = dmem_wen;
        hsize     = {1'b0, dmem_size[1:0]};
        hburst    = 3'b000;
        hmastlock = 1'b0;
        hprot     = HPROT_VAL;
        accept_s  = (htrans == HTRANS_NONSEQ) && hready;
    end

    // Data-phase bookkeeping: capture on acceptance, retire on hready, hold on stall.
    always_comb begin
        dp_valid_d    = dp_valid_q;
        dp_write_d    = dp_write_q;
        dp_size_d     = dp_size_q;
        dp_unsigned_d = dp_unsigned_q;
        dp_off_d      = dp_off_q;
        if (hready) begin
            dp_valid_d = accept_s;
            if (accept_s) begin
                dp_write_d    = dmem_wen;
                dp_size_d     = dmem_size[1:0];
                dp_unsigned_d = dmem_size[2];
                dp_off_d      = dmem_addr[1:0];
            end else begin
                dp_write_d    = dp_write_q;
            end
        end else begin
            dp_valid_d = dp_valid_q;
        end
    end

    // Error tracking: the first ERROR cycle leads to a single ERR2 cycle.
    always_comb begin
        if (state_q == ST_ERR2) begin
            state_d = ST_IDLE_OK;
        end else if (dp_valid_q && hresp && !hready) begin
            state_d = ST_ERR2;
        end else begin
            state_d = ST_IDLE_OK;
        end
    end

    // State and data-phase registers with asynchronous reset.
    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE_OK;
            dp_valid_q    <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_size_q     <= 2'b00;
            dp_unsigned_q <= 1'b0;
            dp_off_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            dp_valid_q    <= dp_valid_d;
            dp_write_q    <= dp_write_d;
            dp_size_q     <= dp_size_d;
            dp_unsigned_q <= dp_unsigned_d;
            dp_off_q      <= dp_off_d;
        end
    end

    // Store data: replicate the narrow value across every byte lane.
    always_comb begin
        case (dp_size_q)
            2'd0:    hwdata = {4{dmem_wdata_delayed[7:0]}};
            2'd1:    hwdata = {2{dmem_wdata_delayed[15:0]}};
            default: hwdata = dmem_wdata_delayed;
        endcase
    end

    // Load data: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        rd_byte_s = hrdata[{dp_off_q, 3'b000} +: 8];
        rd_half_s = hrdata[{dp_off_q[1], 4'b0000} +: 16];
        case (dp_size_q)
            2'd0:    rd_ext_s = {{24{!dp_unsigned_q && rd_byte_s[7]}}, rd_byte_s};
            2'd1:    rd_ext_s = {{16{!dp_unsigned_q && rd_half_s[15]}}, rd_half_s};
            default: rd_ext_s = hrdata;
        endcase
        load_done_s = dp_valid_q && hready && !dp_write_q && (state_q != ST_ERR2);
        if (load_done_s) begin
            dmem_rdata = rd_ext_s;
        end else begin
            dmem_rdata = 32'h0000_0000;
        end
    end

    // Core handshake: stall while the data phase waits; flag bad requests and bus errors.
    always_comb begin
        dmem_wait     = dp_valid_q && !hready;
        dmem_badmem_e = (dmem_en && req_illegal_s) || (state_q == ST_ERR2);
    end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Directed testbench for vscale_dmem_bridge. The bench plays the AHB slave
// by driving hready/hresp/hrdata directly, and checks the core-side and
// bus-side outputs against hand-computed values.
module tb_vscale_dmem_bridge;

    logic        hclk = 1'b0;
    logic        reset;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;
    int xfer_base;

    vscale_dmem_bridge dut (
        .hclk               (hclk),
        .reset              (reset),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_size          (dmem_size),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_rdata         (dmem_rdata),
        .dmem_wait          (dmem_wait),
        .dmem_badmem_e      (dmem_badmem_e),
        .haddr              (haddr),
        .hwrite             (hwrite),
        .hsize              (hsize),
        .hburst             (hburst),
        .hmastlock          (hmastlock),
        .hprot              (hprot),
        .htrans             (htrans),
        .hwdata             (hwdata),
        .hrdata             (hrdata),
        .hready             (hready),
        .hresp              (hresp)
    );

    always #5 hclk = ~hclk;

    // Count accepted address phases seen on the bus.
    always @(posedge hclk) begin
        if (!reset && htrans == 2'b10 && hready) n_xfer <= n_xfer + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic req(input logic en, input logic wen, input logic [2:0] size, input logic [31:0] addr);
        dmem_en   = en;
        dmem_wen  = wen;
        dmem_size = size;
        dmem_addr = addr;
    endtask

    initial begin
        reset = 1'b1;
        req(1'b0, 1'b0, 3'd0, 32'h0);
        dmem_wdata_delayed = 32'h0;
        hrdata = 32'h0;
        hready = 1'b1;
        hresp  = 1'b0;
        repeat (2) @(posedge hclk);
        #3;
        check_eq("rst_htrans", 32'(htrans), 32'h0);
        check_eq("rst_wait",   32'(dmem_wait), 32'h0);
        check_eq("rst_bad",    32'(dmem_badmem_e), 32'h0);
        check_eq("rst_rdata",  dmem_rdata, 32'h0);
        check_eq("tie_hprot",  32'(hprot), 32'h3);
        check_eq("tie_hburst", 32'(hburst), 32'h0);
        check_eq("tie_lock",   32'(hmastlock), 32'h0);
        reset = 1'b0;

        // LW 0x100
        tick();
        req(1'b1, 1'b0, 3'd2, 32'h100);
        #4;
        check_eq("lw_htrans", 32'(htrans), 32'h2);
        check_eq("lw_haddr",  haddr, 32'h100);
        check_eq("lw_hsize",  32'(hsize), 32'h2);
        tick();
        req(1'b0, 1'b0, 3'd0, 32'h0);
        hrdata = 32'hDEADBEEF;
        #4;
        check_eq("lw_rdata",  dmem_rdata, 32'hDEADBEEF);
        check_eq("lw_wait",   32'(dmem_wait), 32'h0);
        check_eq("idle_htrans", 32'(htrans), 32'h0);

        // LB, LBU, LH back to back
        tick();
        req(1'b1, 1'b0, 3'd0, 32'h103);
        tick();
        hrdata = 32'h80FF7F01;
        req(1'b1, 1'b0, 3'd4, 32'h103);
        #4;
        check_eq("lb_rdata", dmem_rdata, 32'hFFFFFF80);
        tick();
        req(1'b1, 1'b0, 3'd1, 32'h102);
        #4;
        check_eq("lbu_rdata", dmem_rdata, 32'h00000080);
        tick();
        req(1'b0, 1'b0, 3'd0, 32'h0);
        #4;
        check_eq("lh_rdata", dmem_rdata, 32'hFFFF80FF);

        // SH 0x202
        tick();
        req(1'b1, 1'b1, 3'd1, 32'h202);
        #4;
        check_eq("sh_hsize",  32'(hsize), 32'h1);
        check_eq("sh_hwrite", 32'(hwrite), 32'h1);
        check_eq("sh_htrans", 32'(htrans), 32'h2);
        tick();
        req(1'b0, 1'b0, 3'd0, 32'h0);
        dmem_wdata_delayed = 32'h0000ABCD;
        #4;
        check_eq("sh_hwdata", hwdata, 32'hABCDABCD);
        check_eq("sh_rdata",  dmem_rdata, 32'h0);

        // SW 0x300 then LW 0x304 with two wait states on the store
        tick();
        xfer_base = n_xfer;
        req(1'b1, 1'b1, 3'd2, 32'h300);
        tick();
        req(1'b1, 1'b0, 3'd2, 32'h304);
        dmem_wdata_delayed = 32'h11223344;
        hready = 1'b0;
        #4;
        check_eq("b2b_wait1",  32'(dmem_wait), 32'h1);
        check_eq("b2b_haddr1", haddr, 32'h304);
        check_eq("b2b_hwdata", hwdata, 32'h11223344);
        tick();
        #4;
        check_eq("b2b_wait2",  32'(dmem_wait), 32'h1);
        check_eq("b2b_haddr2", haddr, 32'h304);
        tick();
        hready = 1'b1;
        #4;
        check_eq("b2b_wait3",   32'(dmem_wait), 32'h0);
        check_eq("b2b_htrans3", 32'(htrans), 32'h2);
        tick();
        req(1'b0, 1'b0, 3'd0, 32'h0);
        hrdata = 32'hCAFEF00D;
        #4;
        check_eq("b2b_rdata", dmem_rdata, 32'hCAFEF00D);
        check_eq("b2b_xfers", 32'(n_xfer - xfer_base), 32'h2);

        // Misaligned LW 0x102 and illegal size 3
        tick();
        xfer_base = n_xfer;
        req(1'b1, 1'b0, 3'd2, 32'h102);
        #4;
        check_eq("mis_bad",    32'(dmem_badmem_e), 32'h1);
        check_eq("mis_htrans", 32'(htrans), 32'h0);
        check_eq("mis_wait",   32'(dmem_wait), 32'h0);
        tick();
        req(1'b1, 1'b0, 3'd3, 32'h0);
        hready = 1'b0;
        #4;
        check_eq("mis_nodp_wait", 32'(dmem_wait), 32'h0);
        check_eq("sz3_bad",    32'(dmem_badmem_e), 32'h1);
        check_eq("sz3_htrans", 32'(htrans), 32'h0);
        tick();
        hready = 1'b1;
        req(1'b0, 1'b0, 3'd0, 32'h0);
        #4;
        check_eq("mis_xfers", 32'(n_xfer - xfer_base), 32'h0);

        // LW 0x400 with ERROR response while LW 0x404 is pending
        tick();
        xfer_base = n_xfer;
        req(1'b1, 1'b0, 3'd2, 32'h400);
        tick();
        req(1'b1, 1'b0, 3'd2, 32'h404);
        hready = 1'b0;
        hresp  = 1'b1;
        hrdata = 32'h12345678;
        #4;
        check_eq("err1_wait", 32'(dmem_wait), 32'h1);
        check_eq("err1_bad",  32'(dmem_badmem_e), 32'h0);
        tick();
        hready = 1'b1;
        #4;
        check_eq("err2_htrans", 32'(htrans), 32'h0);
        check_eq("err2_bad",    32'(dmem_badmem_e), 32'h1);
        check_eq("err2_rdata",  dmem_rdata, 32'h0);
        check_eq("err2_wait",   32'(dmem_wait), 32'h0);
        tick();
        hresp  = 1'b0;
        hready = 1'b0;
        req(1'b0, 1'b0, 3'd0, 32'h0);
        #4;
        check_eq("post_err_wait", 32'(dmem_wait), 32'h0);
        check_eq("post_err_bad",  32'(dmem_badmem_e), 32'h0);
        check_eq("err_xfers",     32'(n_xfer - xfer_base), 32'h1);
        hready = 1'b1;

        // Reset asserted in the middle of a stalled data phase
        tick();
        req(1'b1, 1'b0, 3'd2, 32'h500);
        tick();
        req(1'b0, 1'b0, 3'd0, 32'h0);
        hready = 1'b0;
        #2;
        check_eq("mid_wait", 32'(dmem_wait), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("arst_wait", 32'(dmem_wait), 32'h0);
        tick();
        reset  = 1'b0;
        hready = 1'b1;
        #4;
        check_eq("arst_htrans", 32'(htrans), 32'h0);
        check_eq("arst_rdata",  dmem_rdata, 32'h0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
